// File: rtl/mdu_sequencer_pkg.sv
// Shared MDU definitions for the main controller and the multiply/divide sequencer.
// Holds the MDU op encoding, the sequencer state encoding and the MIPS funct codes
// that the controller decodes into MDU requests or HI/LO reads.
package mdu_sequencer_pkg;

  typedef enum logic [1:0] {
    OpMult  = 2'b00,
    OpMultu = 2'b01,
    OpDiv   = 2'b10,
    OpDivu  = 2'b11
  } mdu_op_e;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StPrep = 3'd1,
    StRun  = 3'd2,
    StFix  = 3'd3,
    StDone = 3'd4
  } mdu_state_e;

  localparam logic [5:0] FunctMfhi  = 6'h10;
  localparam logic [5:0] FunctMflo  = 6'h12;
  localparam logic [5:0] FunctMult  = 6'h18;
  localparam logic [5:0] FunctMultu = 6'h19;
  localparam logic [5:0] FunctDiv   = 6'h1A;
  localparam logic [5:0] FunctDivu  = 6'h1B;

  // Bit 1 of the op selects divide, bit 0 selects unsigned.
  function automatic logic op_is_div(mdu_op_e op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(mdu_op_e op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/mdu_sequencer_if.sv
// Controller <-> MDU request/result bundle.
//   start, op, a, b          : request, driven by the controller (master)
//   busy, done, div_zero     : status, driven by the MDU (slave)
//   hi, lo                   : result registers, driven by the MDU
interface mdu_sequencer_if #(
  parameter int unsigned Width = 32
);
  logic             start;
  logic [1:0]       op;
  logic [Width-1:0] a;
  logic [Width-1:0] b;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [Width-1:0] hi;
  logic [Width-1:0] lo;

  modport master (
    output start, op, a, b,
    input  busy, done, div_zero, hi, lo
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, div_zero, hi, lo
  );
endinterface

// File: rtl/mdu_step.sv
// One radix-2 iteration of the MDU datapath, purely combinational.
//   is_div_i : 0 = shift-add multiply step, 1 = restoring divide step
//   acc_i    : {upper, lower} accumulator ({product hi, multiplier} or {rem, quot})
//   opnd_i   : multiplicand (multiply) or divisor (divide) magnitude
//   acc_o    : accumulator after the iteration
module mdu_step #(
  parameter int unsigned Width = 32
) (
  input  logic               is_div_i,
  input  logic [2*Width-1:0] acc_i,
  input  logic [Width-1:0]   opnd_i,
  output logic [2*Width-1:0] acc_o
);
  logic [Width:0] sum;
  logic [Width:0] rem_sh;
  logic [Width:0] trial;

  always_comb begin
    sum    = {1'b0, acc_i[2*Width-1:Width]} + (acc_i[0] ? {1'b0, opnd_i} : '0);
    // Remainder after the left shift needs one extra bit before the trial subtract.
    rem_sh = acc_i[2*Width-1:Width-1];
    trial  = rem_sh - {1'b0, opnd_i};
    if (is_div_i) begin
      if (!trial[Width]) begin
        acc_o = {trial[Width-1:0], acc_i[Width-2:0], 1'b1};
      end else begin
        acc_o = {rem_sh[Width-1:0], acc_i[Width-2:0], 1'b0};
      end
    end else begin
      // Carry out of the add becomes the new top bit after the right shift.
      acc_o = {sum, acc_i[Width-1:1]};
    end
  end
endmodule

// File: rtl/mdu_sequencer.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer. Signed ops run on magnitudes and the
// sign is fixed up in FIX. Fixed latency of Width+3 edges from start to done.
//   clk_i    : rising-edge clock
//   rst_i    : synchronous active-high reset
//   bus      : slave side of mdu_sequencer_if (request in, busy/done/div_zero/hi/lo out)
module mdu_sequencer
  import mdu_sequencer_pkg::*;
#(
  parameter int unsigned Width = 32
) (
  input logic           clk_i,
  input logic           rst_i,
  mdu_sequencer_if.slave bus
);
  localparam int unsigned CntW = $clog2(Width);
  localparam logic [CntW-1:0] CntLast = CntW'(Width - 1);

  mdu_state_e         state_q;
  mdu_op_e            op_q;
  logic [Width-1:0]   a_q, b_q, opnd_q, hi_q, lo_q;
  logic [2*Width-1:0] acc_q, acc_step, prod_fix;
  logic [CntW-1:0]    cnt_q;
  logic               neg_res_q, neg_rem_q, busy_q, done_q, div_zero_q;

  logic               is_div, a_neg, b_neg;
  logic [Width-1:0]   a_mag, b_mag, quot_fix, rem_fix;

  assign is_div   = op_is_div(op_q);
  assign a_neg    = op_is_signed(op_q) & a_q[Width-1];
  assign b_neg    = op_is_signed(op_q) & b_q[Width-1];
  assign a_mag    = a_neg ? -a_q : a_q;
  assign b_mag    = b_neg ? -b_q : b_q;
  assign prod_fix = neg_res_q ? -acc_q : acc_q;
  assign quot_fix = neg_res_q ? -acc_q[Width-1:0] : acc_q[Width-1:0];
  assign rem_fix  = neg_rem_q ? -acc_q[2*Width-1:Width] : acc_q[2*Width-1:Width];

  mdu_step #(
    .Width(Width)
  ) u_step (
    .is_div_i(is_div),
    .acc_i   (acc_q),
    .opnd_i  (opnd_q),
    .acc_o   (acc_step)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      op_q       <= OpMult;
      a_q        <= '0;
      b_q        <= '0;
      opnd_q     <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            op_q       <= mdu_op_e'(bus.op);
            a_q        <= bus.a;
            b_q        <= bus.b;
            div_zero_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= StPrep;
          end
        end
        StPrep: begin
          neg_res_q <= a_neg ^ b_neg;
          neg_rem_q <= a_neg;
          // Multiply: |a| is added, |b| is shifted out of the low half.
          // Divide: |b| is subtracted, |a| is shifted out of the low half.
          opnd_q    <= is_div ? b_mag : a_mag;
          acc_q     <= {{Width{1'b0}}, (is_div ? a_mag : b_mag)};
          cnt_q     <= '0;
          state_q   <= StRun;
        end
        StRun: begin
          acc_q <= acc_step;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CntLast) begin
            state_q <= StFix;
          end
        end
        StFix: begin
          if (!is_div) begin
            {hi_q, lo_q} <= prod_fix;
          end else if (b_q == '0) begin
            lo_q       <= '1;
            hi_q       <= a_q;
            div_zero_q <= 1'b1;
          end else begin
            lo_q <= quot_fix;
            hi_q <= rem_fix;
          end
          done_q  <= 1'b1;
          state_q <= StDone;
        end
        StDone: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.div_zero = div_zero_q;
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;
endmodule

// File: doc/mdu_sequencer.md
# mdu_sequencer

Multi-cycle multiply/divide sequencer for the MIPS multi-cycle core. It takes one MULT/MULTU/DIV/DIVU request from the main controller and runs a radix-2 shift-add multiply or restoring divide over WIDTH iterations. Results land in its HI/LO registers. It raises `busy` so the controller can stall MFHI/MFLO and further MDU requests, then pulses `done` when HI/LO are valid.

## Interface
- `WIDTH`, 32, operand width; HI and LO are each WIDTH bits
- `clk`  in  1  rising-edge clock; the only clock
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  request; sampled only in IDLE
- `op`  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with `start`
- `a`  in  WIDTH  rs operand (multiplicand / dividend); sampled with `start`
- `b`  in  WIDTH  rt operand (multiplier / divisor); sampled with `start`
- `busy`  out  1  high in every non-IDLE state
- `done`  out  1  one-cycle pulse; HI/LO valid from this cycle on
- `div_zero`  out  1  set at completion of a divide with b==0; cleared by the next accepted `start`
- `hi`  out  WIDTH  product high half / remainder
- `lo`  out  WIDTH  product low half / quotient

## Operation
- States: IDLE, PREP, RUN, FIX, DONE.
- IDLE: if `start`, latch `op`, `a`, `b` and go to PREP. Otherwise stay in IDLE.
- PREP, one cycle:
  - signed ops: take magnitudes |a| and |b|; record `neg_res` = sign(a)^sign(b) and `neg_rem` = sign(a).
  - unsigned ops: both flags are 0.
  - clear the 2·WIDTH accumulator and the iteration counter.
- RUN, exactly WIDTH cycles with counter 0..WIDTH-1:
  - multiply: if multiplier LSB = 1, add the multiplicand into the upper half. Then shift the {carry, acc} right by 1.
  - divide: shift {rem, quot} left by 1 and compute trial = rem − divisor (WIDTH+1 bits). If trial ≥ 0, rem = trial and quot LSB = 1; otherwise quot LSB = 0.
  - leave RUN when counter = WIDTH-1.
- FIX, one cycle, writes HI/LO:
  - multiply: {hi,lo} = `neg_res` ? −acc (2·WIDTH two's complement) : acc.
  - divide with b ≠ 0: lo = `neg_res` ? −quot : quot; hi = `neg_rem` ? −rem : rem.
  - divide with b == 0: lo = all ones, hi = a as latched (unsigned and signed alike); set `div_zero`.
  - signed −2^(WIDTH-1) / −1 needs no special case: it gives lo = 0x80000000, hi = 0.
- DONE, one cycle: `done` = 1, `busy` still 1, then return to IDLE.
- `start` outside IDLE is ignored and never queued. The controller must not assert it while `busy`.
- HI/LO hold their values until the next FIX. Operands are not stored back.

## Timing
- `start` sampled at edge E → PREP at E, RUN covers E+1 … E+WIDTH, FIX at E+WIDTH+1, DONE at E+WIDTH+2.
  - `done` is high for the cycle after edge E+WIDTH+2. Latency is WIDTH+3 edges: 35 at WIDTH=32.
  - `busy` rises after edge E and falls after the edge that leaves DONE.
- Back-to-back: the earliest next `start` is sampled in the IDLE cycle right after the DONE cycle.
- The latency is fixed regardless of operand values, including b == 0.
- Reset (`rst`=1 at any edge, including mid-RUN): state IDLE; `busy`, `done` and `div_zero` 0; `hi` and `lo` 0; counter and accumulator 0. The in-flight operation is dropped with no `done`.
- `rst` takes priority over `start` in the same cycle.

## Structure
- Shared defines file, for both controller and this block:
  - the MDU op encodings (MULT/MULTU/DIV/DIVU);
  - the MDU state encoding;
  - the MIPS funct codes that map to them (0x18–0x1B, MFHI 0x10, MFLO 0x12).
- One sub-module, `mdu_step`: combinational, one iteration, either add-and-shift-right or shift-left-and-trial-subtract selected by an is_div input.
- The sequencer holds the FSM, counter, sign flags, accumulator and HI/LO registers.

## Test plan
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF → `done` 35 edges after `start`; hi=0xFFFFFFFE, lo=0x00000001.
- MULT a=−3 (0xFFFFFFFD), b=7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- DIV a=−7, b=2 → lo=0xFFFFFFFD (−3), hi=0xFFFFFFFF (−1).
- DIVU a=100, b=7 → lo=14, hi=2.
- DIV a=0x80000000, b=−1 → lo=0x80000000, hi=0.
- DIVU a=5, b=0 → lo=0xFFFFFFFF, hi=5, `div_zero`=1, same latency. A following MULTU 2×3 clears `div_zero` and gives lo=6.
- Protocol:
  - `start` pulsed while `busy` → ignored, result unchanged.
  - `rst` asserted at RUN cycle 10 → next cycle busy=0, hi=lo=0, no `done`.
  - a new `start` after reset completes normally.
